// File: rtl/axilite_pkg.sv
// Shared AXI4-Lite response codes and channel FSM state types for the slave and master.
package axilite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

endpackage

// File: rtl/axilite_slave_mem.sv
// Word RAM with one byte-enabled synchronous write port and one synchronous read port.
// A same-address write and read on one edge return the old word (read-first).
module axilite_slave_mem #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 64
) (
    input  logic                     aclk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W/8-1:0]      wstrb,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array and its read register have no reset, so contents survive aresetn.
    // NOTE: non-blocking assignments make the read sample the word before this edge's write.
    always_ff @(posedge aclk) begin
        if (we) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/axilite_slave.sv
// AXI4-Lite responder backed by a byte-strobed word memory decoded over one address window.
// Independent write (AW+W -> B) and read (AR -> R) engines, at most one transaction each in flight.
module axilite_slave
    import axilite_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 64,
    parameter int                DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h1000_0000
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ADDR_W-1:0]     s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_W-1:0]     s_axi_wdata,
    input  logic [DATA_W/8-1:0]   s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_W-1:0]     s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [DATA_W-1:0]     s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int OFF_W  = $clog2(STRB_W);

    function automatic logic in_window(input logic [ADDR_W-1:0] addr);
        return (addr >= BASE_ADDR) && (((addr - BASE_ADDR) >> (IDX_W + OFF_W)) == '0);
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_W-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> OFF_W);
    endfunction

    logic              ready_en;
    wr_state_t         wr_state, wr_next;
    rd_state_t         rd_state, rd_next;
    logic              aw_held, w_held, aw_fire, w_fire, ar_fire, commit;
    logic [ADDR_W-1:0] aw_addr_q, wr_addr;
    logic [DATA_W-1:0] w_data_q, wr_data, mem_rdata;
    logic [STRB_W-1:0] w_strb_q, wr_strb;
    logic              wr_hit, rd_hit_q;
    logic              unused_prot;

    assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

    // Readies stay low through reset and the first edge after its release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) ready_en <= 1'b0;
        else          ready_en <= 1'b1;
    end

    assign s_axi_awready = ready_en && (wr_state == WR_IDLE) && !aw_held;
    assign s_axi_wready  = ready_en && (wr_state == WR_IDLE) && !w_held;
    assign s_axi_bvalid  = (wr_state == WR_RESP);
    assign aw_fire       = s_axi_awvalid && s_axi_awready;
    assign w_fire        = s_axi_wvalid && s_axi_wready;

    // A channel handshaking this cycle bypasses its capture register.
    assign wr_addr = aw_held ? aw_addr_q : s_axi_awaddr;
    assign wr_data = w_held  ? w_data_q  : s_axi_wdata;
    assign wr_strb = w_held  ? w_strb_q  : s_axi_wstrb;
    assign wr_hit  = in_window(wr_addr);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        wr_next = wr_state;
        commit  = 1'b0;
        case (wr_state)
            WR_IDLE: if ((aw_held || aw_fire) && (w_held || w_fire)) begin
                commit  = 1'b1;
                wr_next = WR_RESP;
            end
            WR_RESP: if (s_axi_bready) wr_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state    <= WR_IDLE;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            aw_addr_q   <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            s_axi_bresp <= RESP_OKAY;
        end else begin
            wr_state <= wr_next;
            if (aw_fire) begin
                aw_held   <= 1'b1;
                aw_addr_q <= s_axi_awaddr;
            end
            if (w_fire) begin
                w_held   <= 1'b1;
                w_data_q <= s_axi_wdata;
                w_strb_q <= s_axi_wstrb;
            end
            if (commit) s_axi_bresp <= wr_hit ? RESP_OKAY : RESP_SLVERR;
            if (s_axi_bvalid && s_axi_bready) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    assign s_axi_arready = ready_en && (rd_state == RD_IDLE);
    assign s_axi_rvalid  = (rd_state == RD_DATA);
    assign ar_fire       = s_axi_arvalid && s_axi_arready;

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (ar_fire)      rd_next = RD_DATA;
            RD_DATA: if (s_axi_rready) rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state    <= RD_IDLE;
            rd_hit_q    <= 1'b0;
            s_axi_rresp <= RESP_OKAY;
        end else begin
            rd_state <= rd_next;
            if (ar_fire) begin
                rd_hit_q    <= in_window(s_axi_araddr);
                s_axi_rresp <= in_window(s_axi_araddr) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // The RAM read register only loads on AR handshakes, so rdata holds through RD_DATA.
    assign s_axi_rdata = rd_hit_q ? mem_rdata : '0;

    axilite_slave_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .aclk  (aclk),
        .we    (commit && wr_hit),
        .waddr (word_index(wr_addr)),
        .wdata (wr_data),
        .wstrb (wr_strb),
        .re    (ar_fire),
        .raddr (word_index(s_axi_araddr)),
        .rdata (mem_rdata)
    );

endmodule

// File: doc/axilite_slave.md
# axilite_slave

AXI4-Lite responder that terminates the bus driven by the team's AXI-Lite master and backs it with a byte-strobed word memory. It accepts single-beat writes and reads on independent channels, decodes one contiguous address window, and returns OKAY for hits and SLVERR for misses. It replaces the vendor VIP slave memory in synthesizable test designs and small SoC builds.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 64, data width; STRB_W = DATA_W/8
- DEPTH, 1024, memory words (power of two)
- BASE_ADDR, 'h1000_0000, window start; aligned to DEPTH*STRB_W bytes

Ports:
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  reset, asynchronous, active-low
- s_axi_awaddr / awprot / awvalid  in  ADDR_W / 3 / 1  write address (awprot ignored)
- s_axi_awready  out  1
- s_axi_wdata / wstrb / wvalid  in  DATA_W / STRB_W / 1  write data
- s_axi_wready  out  1
- s_axi_bresp / bvalid  out  2 / 1;  s_axi_bready  in  1  write response
- s_axi_araddr / arprot / arvalid  in  ADDR_W / 3 / 1  read address (arprot ignored)
- s_axi_arready  out  1
- s_axi_rdata / rresp / rvalid  out  DATA_W / 2 / 1;  s_axi_rready  in  1  read data

## Operation
- Decode: hit when BASE_ADDR <= addr < BASE_ADDR + DEPTH*STRB_W; word index = (addr - BASE_ADDR) >> log2(STRB_W); low byte-offset bits ignored.
- Write FSM WR_IDLE / WR_RESP. In WR_IDLE: awready = !aw_held, wready = !w_held. AW and W captured independently, either order or same cycle. On the edge where both are held or handshaking, commit the write (hit only; byte i written iff wstrb[i]), set bresp (OKAY 2'b00 hit, SLVERR 2'b10 miss), bvalid=1, go WR_RESP.
- WR_RESP: awready=wready=0; on bvalid&&bready -> WR_IDLE, clear held flags.
- Read FSM RD_IDLE / RD_DATA. RD_IDLE: arready=1. On AR handshake: rdata = mem[index] (hit) or 0 (miss), rresp OKAY/SLVERR, rvalid=1, go RD_DATA.
- RD_DATA: arready=0; rdata/rresp stable until rvalid&&rready -> RD_IDLE.
- Read and write channels fully independent; both may be active in one cycle.
- Same-word collision (write commit and read fetch on one edge): read returns old data.
- wstrb=0 on a hit: no bytes change, bresp OKAY.

## Timing
- Reset values: awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=2'b00, rdata=0; held flags clear; FSMs idle. Memory contents not reset and retained across reset.
- Readies held low while aresetn low and for the first edge after release; asserted from the second cycle.
- Write latency: bvalid high the cycle after the later of the AW/W handshakes; memory updated at that same edge.
- Read latency: rvalid high the cycle after AR handshake.
- Peak throughput with bready/rready tied high: one write and one read every 2 cycles.
- Reset mid-transaction: pending AW/W/response or read response dropped immediately; a commit not yet clocked does not occur.
- No outstanding-transaction queueing: at most one write and one read in flight.

## Structure
- Package axilite_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, wr_state_t {WR_IDLE, WR_RESP}, rd_state_t {RD_IDLE, RD_DATA}; shared with the master.
- Sub-module axilite_slave_mem: DEPTH x DATA_W RAM, one byte-enabled synchronous write port, one synchronous read port, read-first on same-address collision.
- Top holds both FSMs, capture registers, decode.

## Test plan
- Write 0x1000_0000 = 0xF8F4F2F1, strb 0xFF, AW/W same cycle -> bvalid next cycle, bresp 0; read back -> rdata 0x00000000F8F4F2F1, rresp 0, rvalid one cycle after AR.
- Prefill 0x1000_0040 = all ones; write 0xBADCAFEEBADCAFEE strb 0x0F -> read 0xFFFFFFFFBADCAFEE; strb 0xAA on 0xDEADBEEFDEADBEEF over zeros -> 0xDE00BE00DE00BE00.
- W presented 3 cycles before AW -> wready drops after W handshake, memory write and bvalid one cycle after AW handshake.
- Write and read 0x3000_1540 (outside window) -> bresp 2'b10, no memory change; rdata 0, rresp 2'b10.
- bready low 5 cycles -> bvalid/bresp held, awready=wready=0 throughout; rready low 5 cycles -> rdata stable, arready=0.
- Assert aresetn low during WR_RESP -> bvalid 0 immediately; readies 0 until second cycle after release; previously written data still readable.
